// File: rtl/dht11_responder_if.sv
// rtl/dht11_responder_if.sv - control/status bundle between a host-side controller and the DHT11 responder
interface dht11_responder_if;
  logic       enable;
  logic       corrupt_checksum;
  logic [7:0] hum_int;
  logic [7:0] hum_float;
  logic [7:0] temp_int;
  logic [7:0] temp_float;
  logic       busy;
  logic       frame_done;
  logic       start_error;

  modport master (
    output enable, corrupt_checksum, hum_int, hum_float, temp_int, temp_float,
    input  busy, frame_done, start_error
  );

  modport slave (
    input  enable, corrupt_checksum, hum_int, hum_float, temp_int, temp_float,
    output busy, frame_done, start_error
  );
endinterface

// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 device-side emulator: answers a host start pulse with ACK and a 40-bit frame
module dht11_responder #(
  parameter int CLOCK_FREQ_MHZ = 50,
  parameter int START_MIN_US   = 18000,
  parameter int WAIT_US        = 30,
  parameter int ACK_LOW_US     = 80,
  parameter int ACK_HIGH_US    = 80,
  parameter int BIT_LOW_US     = 50,
  parameter int ZERO_HIGH_US   = 26,
  parameter int ONE_HIGH_US    = 70
) (
  input  logic           clock,
  input  logic           reset,
  inout  wire            transmission_line,
  dht11_responder_if.slave ctrl
);
  localparam int US_W  = $clog2(START_MIN_US + 1);
  localparam int PRE_W = (CLOCK_FREQ_MHZ > 1) ? $clog2(CLOCK_FREQ_MHZ) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(CLOCK_FREQ_MHZ - 1);
  localparam logic [US_W-1:0]  START_MIN    = US_W'(START_MIN_US);
  localparam logic [US_W-1:0]  WAIT_M1      = US_W'(WAIT_US - 1);
  localparam logic [US_W-1:0]  ACK_LOW_M1   = US_W'(ACK_LOW_US - 1);
  localparam logic [US_W-1:0]  ACK_HIGH_M1  = US_W'(ACK_HIGH_US - 1);
  localparam logic [US_W-1:0]  BIT_LOW_M1   = US_W'(BIT_LOW_US - 1);
  localparam logic [US_W-1:0]  ZERO_HIGH_M1 = US_W'(ZERO_HIGH_US - 1);
  localparam logic [US_W-1:0]  ONE_HIGH_M1  = US_W'(ONE_HIGH_US - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START_LOW, S_WAIT, S_ACK_LOW, S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
  } state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q;
  logic [US_W-1:0]   us_q;
  logic [1:0]        sync_q;
  logic [1:0]        own_q;
  logic              drive_low_q, drive_low_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              start_error_q, start_error_d;
  logic [39:0]       shift_q, shift_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;

  logic              line_s, self_drive, us_tick, phase_done, abort;
  logic [US_W-1:0]   phase_m1;
  logic [7:0]        chk;

  assign transmission_line = drive_low_q ? 1'b0 : 1'bz;
  assign ctrl.busy         = busy_q;
  assign ctrl.frame_done   = frame_done_q;
  assign ctrl.start_error  = start_error_q;

  // Our own low drive echoes through the synchronizer for two cycles after release; mask it from start detection.
  assign line_s     = sync_q[1];
  assign self_drive = drive_low_q | (|own_q);
  assign us_tick    = (pre_q == PRE_LAST);
  assign abort      = !ctrl.enable && (state_q != S_IDLE);
  assign chk        = (ctrl.hum_int + ctrl.hum_float + ctrl.temp_int + ctrl.temp_float)
                      ^ {7'b0, ctrl.corrupt_checksum};

  always_comb begin
    phase_m1 = '0;
    case (state_q)
      S_WAIT:               phase_m1 = WAIT_M1;
      S_ACK_LOW:            phase_m1 = ACK_LOW_M1;
      S_ACK_HIGH:           phase_m1 = ACK_HIGH_M1;
      S_BIT_LOW, S_END_LOW: phase_m1 = BIT_LOW_M1;
      S_BIT_HIGH:           phase_m1 = shift_q[39] ? ONE_HIGH_M1 : ZERO_HIGH_M1;
      default:              phase_m1 = '0;
    endcase
  end

  assign phase_done = us_tick && (us_q == phase_m1);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (ctrl.enable && !line_s && !self_drive) state_d = S_START_LOW;
        S_START_LOW: if (line_s) state_d = (us_q >= START_MIN) ? S_WAIT : S_IDLE;
        S_WAIT:      if (phase_done) state_d = S_ACK_LOW;
        S_ACK_LOW:   if (phase_done) state_d = S_ACK_HIGH;
        S_ACK_HIGH:  if (phase_done) state_d = S_BIT_LOW;
        S_BIT_LOW:   if (phase_done) state_d = S_BIT_HIGH;
        S_BIT_HIGH:  if (phase_done) state_d = (bit_cnt_q == 6'd39) ? S_END_LOW : S_BIT_LOW;
        S_END_LOW:   if (phase_done) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    drive_low_d   = drive_low_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    start_error_d = 1'b0;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    if (abort) begin
      drive_low_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_START_LOW: if (line_s) begin
          if (us_q >= START_MIN) begin
            shift_d   = {ctrl.hum_int, ctrl.hum_float, ctrl.temp_int, ctrl.temp_float, chk};
            bit_cnt_d = '0;
            busy_d    = 1'b1;
          end else begin
            start_error_d = 1'b1;
          end
        end
        S_WAIT:     if (phase_done) drive_low_d = 1'b1;
        S_ACK_LOW:  if (phase_done) drive_low_d = 1'b0;
        S_ACK_HIGH: if (phase_done) drive_low_d = 1'b1;
        S_BIT_LOW:  if (phase_done) drive_low_d = 1'b0;
        S_BIT_HIGH: if (phase_done) begin
          shift_d     = {shift_q[38:0], 1'b0};
          bit_cnt_d   = bit_cnt_q + 6'd1;
          drive_low_d = 1'b1;
        end
        S_END_LOW:  if (phase_done) begin
          drive_low_d  = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_q         <= '0;
      us_q          <= '0;
      sync_q        <= 2'b11;
      own_q         <= 2'b00;
      drive_low_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      start_error_q <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
    end else begin
      sync_q        <= {sync_q[0], transmission_line};
      own_q         <= {own_q[0], drive_low_q};
      drive_low_q   <= drive_low_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      start_error_q <= start_error_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      if (state_d != state_q) begin
        pre_q <= '0;
        us_q  <= '0;
      end else if (us_tick) begin
        pre_q <= '0;
        if (us_q != START_MIN) us_q <= us_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - directed self-checking bench for dht11_responder acting as host and decoder
module tb_dht11_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic host_low = 1'b0;
  wire  line;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0, se_cnt = 0, both_cnt = 0, dut_low_cnt = 0, busy_cnt = 0;

  dht11_responder_if ifc();

  assign line = host_low ? 1'b0 : 1'bz;
  pullup (line);

  dht11_responder #(
    .CLOCK_FREQ_MHZ(1), .START_MIN_US(1000), .WAIT_US(30), .ACK_LOW_US(80),
    .ACK_HIGH_US(80), .BIT_LOW_US(50), .ZERO_HIGH_US(26), .ONE_HIGH_US(70)
  ) dut (
    .clock(clock), .reset(reset), .transmission_line(line), .ctrl(ifc)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ifc.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (ifc.start_error === 1'b1) se_cnt <= se_cnt + 1;
    if (ifc.frame_done === 1'b1 && ifc.start_error === 1'b1) both_cnt <= both_cnt + 1;
    if (!host_low && line === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
    if (ifc.busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic host_start(input int low_us);
    @(negedge clock);
    host_low = 1'b1;
    tick(low_us);
    host_low = 1'b0;
    @(negedge clock);
  endtask

  // Counts consecutive negedge samples at level lvl; -1 when the bound expires.
  task automatic measure(input logic lvl, input bit chk_busy, inout bit busy_ok, output int n);
    n = 0;
    while (line === lvl && n < 400) begin
      if (chk_busy && ifc.busy !== 1'b1) busy_ok = 1'b0;
      n++;
      @(negedge clock);
    end
    if (n >= 400) n = -1;
  endtask

  logic [39:0] r_data;
  bit          r_ok, r_bits_ok, r_busy_ok, r_aborted;
  int          r_dack, r_alo, r_ahi, r_elo;

  task automatic receive(input int abort_bit, input bit mod_ack_high);
    int  lo, hi;
    logic b;
    r_data = '0; r_ok = 1; r_bits_ok = 1; r_busy_ok = 1; r_aborted = 0; r_elo = 0;
    measure(1'b1, 1'b0, r_busy_ok, r_dack);
    measure(1'b0, 1'b1, r_busy_ok, r_alo);
    if (mod_ack_high) ifc.temp_int = 8'h55;
    measure(1'b1, 1'b1, r_busy_ok, r_ahi);
    if (r_dack < 0 || r_alo < 0 || r_ahi < 0) r_ok = 0;
    for (int i = 0; i < 40; i++) begin
      measure(1'b0, 1'b1, r_busy_ok, lo);
      if (lo != 50) r_bits_ok = 0;
      if (i == abort_bit) begin
        tick(5);
        ifc.enable = 1'b0;
        @(negedge clock);
        r_aborted = 1;
        break;
      end
      measure(1'b1, 1'b1, r_busy_ok, hi);
      if (!(hi == 26 || hi == 70)) r_bits_ok = 0;
      b = (hi > 48);
      r_data = {r_data[38:0], b};
    end
    if (!r_aborted) begin
      measure(1'b0, 1'b1, r_busy_ok, r_elo);
      if (r_elo < 0) r_ok = 0;
    end
  endtask

  task automatic frame_checks(input string p, input logic [39:0] exp_data, input int fd0, input int se0);
    check({p, "_ok"}, r_ok, 1'b1);
    check({p, "_ack_delay"}, (r_dack >= 30 && r_dack <= 34), 1'b1);
    check({p, "_ack_low"}, r_alo, 80);
    check({p, "_ack_high"}, r_ahi, 80);
    check({p, "_data"}, r_data, exp_data);
    check({p, "_bit_timing"}, r_bits_ok, 1'b1);
    check({p, "_end_low"}, r_elo, 50);
    check({p, "_busy_held"}, r_busy_ok, 1'b1);
    tick(5);
    check({p, "_busy_after"}, ifc.busy, 1'b0);
    check({p, "_frame_done_cnt"}, fd_cnt - fd0, 1);
    check({p, "_start_err_cnt"}, se_cnt - se0, 0);
  endtask

  int fd0, se0, dl0, bz0;

  initial begin
    ifc.enable = 1'b1; ifc.corrupt_checksum = 1'b0;
    ifc.hum_int = 8'h37; ifc.hum_float = 8'h00; ifc.temp_int = 8'h18; ifc.temp_float = 8'h03;
    reset = 1'b0;
    tick(4);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_frame_done", ifc.frame_done, 1'b0);
    check("rst_start_error", ifc.start_error, 1'b0);
    check("rst_line", line, 1'b1);
    reset = 1'b1;
    tick(5);

    // normal frame
    fd0 = fd_cnt; se0 = se_cnt;
    host_start(1200);
    receive(-1, 1'b0);
    frame_checks("t1", 40'h37_00_18_03_52, fd0, se0);

    // short start
    fd0 = fd_cnt; se0 = se_cnt; dl0 = dut_low_cnt; bz0 = busy_cnt;
    host_start(500);
    tick(200);
    check("t2_start_err_cnt", se_cnt - se0, 1);
    check("t2_dut_low", dut_low_cnt - dl0, 0);
    check("t2_busy_cycles", busy_cnt - bz0, 0);
    check("t2_frame_done_cnt", fd_cnt - fd0, 0);

    // checksum wrap, then injection
    ifc.hum_int = 8'hFF; ifc.hum_float = 8'hFF; ifc.temp_int = 8'h01; ifc.temp_float = 8'h01;
    fd0 = fd_cnt; se0 = se_cnt;
    host_start(1200);
    receive(-1, 1'b0);
    frame_checks("t3a", 40'hFF_FF_01_01_00, fd0, se0);
    ifc.corrupt_checksum = 1'b1;
    fd0 = fd_cnt; se0 = se_cnt;
    host_start(1200);
    receive(-1, 1'b0);
    frame_checks("t3b", 40'hFF_FF_01_01_01, fd0, se0);
    ifc.corrupt_checksum = 1'b0;

    // enable abort during bit 20 high phase
    ifc.hum_int = 8'h37; ifc.hum_float = 8'h00; ifc.temp_int = 8'h18; ifc.temp_float = 8'h03;
    fd0 = fd_cnt;
    host_start(1200);
    receive(20, 1'b0);
    check("t4_aborted", r_aborted, 1'b1);
    check("t4_busy", ifc.busy, 1'b0);
    check("t4_line", line, 1'b1);
    dl0 = dut_low_cnt;
    tick(200);
    check("t4_no_frame_done", fd_cnt - fd0, 0);
    check("t4_line_released", dut_low_cnt - dl0, 0);
    ifc.enable = 1'b1;
    fd0 = fd_cnt; se0 = se_cnt;
    host_start(1200);
    receive(-1, 1'b0);
    frame_checks("t4_next", 40'h37_00_18_03_52, fd0, se0);

    // reset in the middle of ACK_LOW
    fd0 = fd_cnt; se0 = se_cnt;
    host_start(1200);
    measure(1'b1, 1'b0, r_busy_ok, r_dack);
    check("t5_ack_seen", (r_dack >= 30 && r_dack <= 34), 1'b1);
    tick(20);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("t5_line", line, 1'b1);
    check("t5_busy", ifc.busy, 1'b0);
    check("t5_frame_done", ifc.frame_done, 1'b0);
    check("t5_start_error", ifc.start_error, 1'b0);
    dl0 = dut_low_cnt; bz0 = busy_cnt;
    tick(100);
    check("t5_idle_line", dut_low_cnt - dl0, 0);
    check("t5_idle_busy", busy_cnt - bz0, 0);
    check("t5_no_pulses", (fd_cnt - fd0) + (se_cnt - se0), 0);

    // data change during ACK_HIGH must not reach the frame
    fd0 = fd_cnt; se0 = se_cnt;
    host_start(1200);
    receive(-1, 1'b1);
    frame_checks("t6", 40'h37_00_18_03_52, fd0, se0);

    check("never_both_pulses", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
